// File: rtl/rv_id_pkg.sv
// Shared RV32I decode constants: opcodes, op classes, funct7 values, immediate formats.
package rv_id_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ALUI   = 7'b0010011;
  localparam logic [6:0] OPC_ALU    = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam int unsigned OP_LUI    = 0;
  localparam int unsigned OP_AUIPC  = 1;
  localparam int unsigned OP_JAL    = 2;
  localparam int unsigned OP_JALR   = 3;
  localparam int unsigned OP_BRANCH = 4;
  localparam int unsigned OP_LOAD   = 5;
  localparam int unsigned OP_STORE  = 6;
  localparam int unsigned OP_ALUI   = 7;
  localparam int unsigned OP_ALU    = 8;
  localparam int unsigned OP_FENCE  = 9;
  localparam int unsigned OP_SYSTEM = 10;
  localparam int unsigned OP_MUL    = 11;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

endpackage

// File: rtl/rv_id_stage_if.sv
// IF -> ID -> EX handshake and regfile read bundle for rv_id_stage.
interface rv_id_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32,
  parameter int unsigned OP_W = 4
);
  logic            flush;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_inst;
  logic [PC_W-1:0] if_pc;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_rdata;
  logic [XLEN-1:0] rs2_rdata;
  logic            ex_valid;
  logic            ex_ready;
  logic [PC_W-1:0] ex_pc;
  logic [OP_W-1:0] ex_op;
  logic [2:0]      ex_funct3;
  logic            ex_alt;
  logic [4:0]      ex_rs1_idx;
  logic [4:0]      ex_rs2_idx;
  logic [4:0]      ex_rd;
  logic            ex_rd_we;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic [XLEN-1:0] ex_imm;
  logic            ex_illegal;

  modport slave (
    input  flush, if_valid, if_inst, if_pc, rs1_rdata, rs2_rdata, ex_ready,
    output if_ready, rs1_addr, rs2_addr, ex_valid, ex_pc, ex_op, ex_funct3, ex_alt,
           ex_rs1_idx, ex_rs2_idx, ex_rd, ex_rd_we, ex_rs1_val, ex_rs2_val, ex_imm, ex_illegal
  );

  modport master (
    output flush, if_valid, if_inst, if_pc, rs1_rdata, rs2_rdata, ex_ready,
    input  if_ready, rs1_addr, rs2_addr, ex_valid, ex_pc, ex_op, ex_funct3, ex_alt,
           ex_rs1_idx, ex_rs2_idx, ex_rd, ex_rd_we, ex_rs1_val, ex_rs2_val, ex_imm, ex_illegal
  );
endinterface

// File: rtl/rv_imm_gen.sv
// Immediate extraction for RV32I formats, sign-extended to XLEN.
module rv_imm_gen
  import rv_id_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm_c
);

  logic signed [31:0] raw;

  // Build the 32-bit signed immediate, then widen; the signed cast sign-extends for XLEN=64.
  always_comb begin
    raw = '0;
    case (fmt)
      IMM_I:   raw = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   raw = {inst[31:12], 12'b0};
      IMM_J:   raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: raw = '0;
    endcase
    imm_c = XLEN'(raw);
  end

endmodule

// File: rtl/rv_id_stage.sv
// RV32I decode stage with registered ID/EX boundary, flush and load-use bubble insertion.
// Optional M-extension decode enabled by defining RV_ID_MEXT_EN.
module rv_id_stage
  import rv_id_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32,
  parameter int unsigned OP_W = 4
) (
  input logic         clk,
  input logic         rst_n,
  rv_id_stage_if.slave bus
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [OP_W-1:0] op_c;
  imm_fmt_e        fmt_c;
  logic            wr_c;
  logic            illegal_c;
  logic            rs1_used_c;
  logic            rs2_used_c;
  logic            rd_kill_c;
  logic [4:0]      rd_c;
  logic            rd_we_c;
  logic [XLEN-1:0] imm_c;
  logic            advance_c;
  logic            hazard_c;
  logic            capture_c;

  assign opcode = bus.if_inst[6:0];
  assign funct3 = bus.if_inst[14:12];
  assign funct7 = bus.if_inst[31:25];

  // Opcode decode; illegal encodings collapse to a non-writing ALU op.
  always_comb begin
    op_c       = OP_W'(OP_ALU);
    fmt_c      = IMM_NONE;
    wr_c       = 1'b0;
    illegal_c  = 1'b0;
    rs1_used_c = 1'b1;
    rs2_used_c = 1'b1;
    rd_kill_c  = 1'b0;
    case (opcode)
      OPC_LUI:    begin op_c = OP_W'(OP_LUI);   fmt_c = IMM_U; wr_c = 1'b1; rs1_used_c = 1'b0; rs2_used_c = 1'b0; end
      OPC_AUIPC:  begin op_c = OP_W'(OP_AUIPC); fmt_c = IMM_U; wr_c = 1'b1; rs1_used_c = 1'b0; rs2_used_c = 1'b0; end
      OPC_JAL:    begin op_c = OP_W'(OP_JAL);   fmt_c = IMM_J; wr_c = 1'b1; rs1_used_c = 1'b0; rs2_used_c = 1'b0; end
      OPC_JALR: begin
        op_c = OP_W'(OP_JALR); fmt_c = IMM_I; wr_c = 1'b1; rs2_used_c = 1'b0;
        illegal_c = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin op_c = OP_W'(OP_BRANCH); fmt_c = IMM_B; rd_kill_c = 1'b1; end
      OPC_LOAD:   begin op_c = OP_W'(OP_LOAD);   fmt_c = IMM_I; wr_c = 1'b1; rs2_used_c = 1'b0; end
      OPC_STORE:  begin op_c = OP_W'(OP_STORE);  fmt_c = IMM_S; rd_kill_c = 1'b1; end
      OPC_ALUI:   begin op_c = OP_W'(OP_ALUI);   fmt_c = IMM_I; wr_c = 1'b1; rs2_used_c = 1'b0; end
      OPC_ALU: begin
        wr_c = 1'b1;
        if (funct7 == F7_BASE || funct7 == F7_ALT) op_c = OP_W'(OP_ALU);
`ifdef RV_ID_MEXT_EN
        else if (funct7 == F7_MULDIV) op_c = OP_W'(OP_MUL);
`endif
        else illegal_c = 1'b1;
      end
      OPC_FENCE:  begin op_c = OP_W'(OP_FENCE); rs2_used_c = 1'b0; end
      // CSR forms write rd; ECALL/EBREAK (funct3=0) do not.
      OPC_SYSTEM: begin op_c = OP_W'(OP_SYSTEM); fmt_c = IMM_I; rs2_used_c = 1'b0; wr_c = (funct3 != 3'b000); end
      default:    illegal_c = 1'b1;
    endcase
    if (illegal_c) begin
      op_c  = OP_W'(OP_ALU);
      wr_c  = 1'b0;
      fmt_c = IMM_NONE;
    end
  end

  assign bus.rs1_addr = rs1_used_c ? bus.if_inst[19:15] : 5'd0;
  assign bus.rs2_addr = rs2_used_c ? bus.if_inst[24:20] : 5'd0;
  assign rd_c         = rd_kill_c ? 5'd0 : bus.if_inst[11:7];
  assign rd_we_c      = wr_c && (rd_c != 5'd0);

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst  (bus.if_inst),
    .fmt   (fmt_c),
    .imm_c (imm_c)
  );

  // Load-use stall: the loaded value is not available until after EX.
  assign advance_c   = !bus.ex_valid || bus.ex_ready;
  assign hazard_c    = bus.ex_valid && (bus.ex_op == OP_W'(OP_LOAD)) && (bus.ex_rd != 5'd0) &&
                       ((bus.ex_rd == bus.rs1_addr) || (bus.ex_rd == bus.rs2_addr)) && bus.if_valid;
  assign bus.if_ready = (advance_c && !hazard_c) || bus.flush;
  assign capture_c    = advance_c && bus.if_valid && !hazard_c && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       bus.ex_valid <= 1'b0;
    else if (capture_c)               bus.ex_valid <= 1'b1;
    else if (advance_c || bus.flush)  bus.ex_valid <= 1'b0;
  end

  // Payload only loads on capture so bubbles and stalls leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_pc      <= PC_W'(0);
      bus.ex_op      <= '0;
      bus.ex_funct3  <= '0;
      bus.ex_alt     <= 1'b0;
      bus.ex_rs1_idx <= '0;
      bus.ex_rs2_idx <= '0;
      bus.ex_rd      <= '0;
      bus.ex_rd_we   <= 1'b0;
      bus.ex_rs1_val <= '0;
      bus.ex_rs2_val <= '0;
      bus.ex_imm     <= '0;
      bus.ex_illegal <= 1'b0;
    end else if (capture_c) begin
      bus.ex_pc      <= bus.if_pc;
      bus.ex_op      <= op_c;
      bus.ex_funct3  <= funct3;
      bus.ex_alt     <= bus.if_inst[30];
      bus.ex_rs1_idx <= bus.rs1_addr;
      bus.ex_rs2_idx <= bus.rs2_addr;
      bus.ex_rd      <= rd_c;
      bus.ex_rd_we   <= rd_we_c;
      bus.ex_rs1_val <= bus.rs1_rdata;
      bus.ex_rs2_val <= bus.rs2_rdata;
      bus.ex_imm     <= imm_c;
      bus.ex_illegal <= illegal_c;
    end
  end

endmodule

// File: tb/tb_rv_id_stage.sv
// Scoreboard bench for rv_id_stage: directed instructions, hazard, backpressure, flush and reset.
module tb_rv_id_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PC_W = 32;
  localparam int unsigned OP_W = 4;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [OP_W-1:0] op;
    logic [2:0]      funct3;
    logic            alt;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  rv_id_stage_if #(.XLEN(XLEN), .PC_W(PC_W), .OP_W(OP_W)) bus ();

  rv_id_stage #(.XLEN(XLEN), .PC_W(PC_W), .OP_W(OP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [XLEN-1:0] rf(input logic [4:0] a);
    return (a == 5'd0) ? '0 : (XLEN'(32'hA000_0000) | XLEN'(a));
  endfunction

  // Register file model: same-cycle read data derived from the address.
  assign bus.rs1_rdata = rf(bus.rs1_addr);
  assign bus.rs2_rdata = rf(bus.rs2_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [PC_W-1:0] pc, input int op, input logic [2:0] f3,
                              input logic alt, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic we, input logic [XLEN-1:0] imm,
                              input logic ill);
    exp_t e;
    e.pc = pc; e.op = OP_W'(op); e.funct3 = f3; e.alt = alt;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.rd_we = we;
    e.rs1_val = rf(rs1); e.rs2_val = rf(rs2); e.imm = imm; e.illegal = ill;
    return e;
  endfunction

  function automatic exp_t cur();
    exp_t e;
    e.pc = bus.ex_pc; e.op = bus.ex_op; e.funct3 = bus.ex_funct3; e.alt = bus.ex_alt;
    e.rs1 = bus.ex_rs1_idx; e.rs2 = bus.ex_rs2_idx; e.rd = bus.ex_rd; e.rd_we = bus.ex_rd_we;
    e.rs1_val = bus.ex_rs1_val; e.rs2_val = bus.ex_rs2_val; e.imm = bus.ex_imm;
    e.illegal = bus.ex_illegal;
    return e;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: every EX handshake must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.ex_valid && bus.ex_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ex act=%h exp=none", cur());
      end else begin
        e = sb.pop_front();
        chk("ex_xfer", 256'(cur()), 256'(e));
      end
    end
  end

  // Present one instruction until accepted; the expectation is queued on acceptance.
  task automatic send(input logic [31:0] inst, input logic [PC_W-1:0] pc, input exp_t e,
                      input bit keep);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = bus.if_ready && !bus.flush;
      if (acc && keep) sb.push_back(e);
      @(posedge clk);
      #1;
      n++;
    end
    bus.if_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout act=not_accepted exp=accepted inst=%h", inst);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_inst = 32'h0;
    bus.if_pc = '0;
    bus.ex_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 256'({bus.ex_valid, cur()}), 256'(0));
    chk("reset_if_ready", 256'(bus.if_ready), 256'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // addi x1,x0,5
    send(32'h00500093, 32'h100, mk(32'h100, 7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, XLEN'(5), 1'b0), 1'b1);
    chk("latency_valid", 256'(bus.ex_valid), 256'(1));

    // lw x2,0(x1) followed by add x3,x2,x2: one-cycle stall and one bubble
    send(32'h0000A103, 32'h104, mk(32'h104, 5, 3'd2, 1'b0, 5'd1, 5'd0, 5'd2, 1'b1, XLEN'(0), 1'b0), 1'b1);
    bus.if_valid = 1'b1;
    bus.if_inst  = 32'h002101B3;
    bus.if_pc    = 32'h108;
    @(negedge clk);
    chk("hazard_stall", 256'(bus.if_ready), 256'(0));
    @(posedge clk);
    #1;
    chk("hazard_bubble", 256'(bus.ex_valid), 256'(0));
    send(32'h002101B3, 32'h108, mk(32'h108, 8, 3'd0, 1'b0, 5'd2, 5'd2, 5'd3, 1'b1, XLEN'(0), 1'b0), 1'b1);

    // beq x0,x0,-4
    send(32'hFE000EE3, 32'h10C, mk(32'h10C, 4, 3'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, XLEN'(32'hFFFF_FFFC), 1'b0), 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure then flush: addi x5,x0,7 is held, then killed; addi x6,x0,9 is discarded
    bus.ex_ready = 1'b0;
    send(32'h00700293, 32'h300, mk(32'h300, 7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, XLEN'(7), 1'b0), 1'b0);
    bus.if_valid = 1'b1;
    bus.if_inst  = 32'h00900313;
    bus.if_pc    = 32'h304;
    @(negedge clk);
    chk("bp_ready", 256'(bus.if_ready), 256'(0));
    chk("bp_hold0", 256'({bus.ex_valid, bus.ex_pc, bus.ex_rd, bus.ex_imm}),
        256'({1'b1, PC_W'(32'h300), 5'd5, XLEN'(7)}));
    @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", 256'(bus.if_ready), 256'(1));
    chk("bp_hold1", 256'({bus.ex_valid, bus.ex_pc, bus.ex_rd, bus.ex_imm}),
        256'({1'b1, PC_W'(32'h300), 5'd5, XLEN'(7)}));
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
    chk("flush_kill", 256'(bus.ex_valid), 256'(0));
    @(posedge clk);
    #1;
    chk("flush_discard", 256'(bus.ex_valid), 256'(0));
    bus.ex_ready = 1'b1;

    // Illegal all-ones word
    send(32'hFFFFFFFF, 32'h200, mk(32'h200, 8, 3'd7, 1'b1, 5'd31, 5'd31, 5'd31, 1'b0, XLEN'(0), 1'b1), 1'b1);

    // mul x3,x1,x2
`ifdef RV_ID_MEXT_EN
    send(32'h022081B3, 32'h204, mk(32'h204, 11, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, XLEN'(0), 1'b0), 1'b1);
`else
    send(32'h022081B3, 32'h204, mk(32'h204, 8, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, XLEN'(0), 1'b1), 1'b1);
`endif

    // lui x7,0x80000: U immediate with sign bit set
    send(32'h800003B7, 32'h208, mk(32'h208, 0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, XLEN'(32'h8000_0000), 1'b0), 1'b1);
    // sw x2,-1(x1): S immediate all ones, no rd write
    send(32'hFE20AFA3, 32'h20C, mk(32'h20C, 6, 3'd2, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, XLEN'(32'hFFFF_FFFF), 1'b0), 1'b1);
    // jal x0,8: rd=0 suppresses write enable
    send(32'h0080006F, 32'h210, mk(32'h210, 2, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, XLEN'(8), 1'b0), 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset while the ID/EX register holds a stalled instruction
    bus.ex_ready = 1'b0;
    send(32'h00500093, 32'h400, mk(32'h400, 7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, XLEN'(5), 1'b0), 1'b0);
    chk("pre_reset_valid", 256'(bus.ex_valid), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 256'({bus.ex_valid, cur()}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.ex_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    chk("sb_empty", 256'(sb.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
